// File: rtl/riscv_mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one single-port synchronous RAM.
// Data wins by default; a bounded starvation counter guarantees fetch forward progress.
module riscv_mem_arbiter #(
  parameter logic [31:0] TEXT_BASE    = 32'h00000000,
  parameter logic [31:0] DATA_BASE    = 32'h00002000,
  parameter int          DATA_WORDS   = 2048,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iMemRead,
  input  logic [31:0] PC,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] instruction,
  output logic [31:0] dReadData,
  output logic        iStall,
  output logic        dStall,
  output logic        iValid,
  output logic        dValid,
  output logic        dErr,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int              SW               = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   LIM              = SW'(STARVE_LIMIT);
  localparam logic [31:0]     DATA_WORD_OFFSET = (DATA_BASE - TEXT_BASE) >> 2;
  localparam logic [32:0]     DATA_END         = {1'b0, DATA_BASE} + 33'(4 * DATA_WORDS);
  localparam logic [31:0]     NOP              = 32'h00000013;

  typedef enum logic [1:0] {RD_NONE, RD_FETCH, RD_DATA, RD_ERR} rd_src_t;

  rd_src_t       r_rd_src, w_rd_src_nxt;
  logic [SW-1:0] r_starve_cnt;
  logic          r_err;
  logic [31:0]   r_instr, r_dread;

  logic          w_dreq, w_oor, w_grant_i, w_grant_d;
  logic [31:0]   w_iidx, w_didx;

  assign w_dreq    = MemRead | MemWrite;
  assign w_oor     = ({1'b0, dAddress} < {1'b0, DATA_BASE}) || ({1'b0, dAddress} >= DATA_END);
  // Grants are suppressed during reset so the RAM sees no enable while rst is high.
  assign w_grant_i = ~rst & iMemRead & (~w_dreq | (r_starve_cnt == LIM));
  assign w_grant_d = ~rst & w_dreq & ~w_grant_i;

  assign w_iidx    = (PC - TEXT_BASE) >> 2;
  assign w_didx    = DATA_WORD_OFFSET + ((dAddress - DATA_BASE) >> 2);

  assign mem_en    = w_grant_i | (w_grant_d & ~w_oor);
  assign mem_we    = w_grant_d & MemWrite & ~w_oor;
  assign mem_addr  = w_grant_i ? w_iidx : w_didx;
  assign mem_wdata = dWriteData;

  assign iStall    = iMemRead & ~w_grant_i;
  assign dStall    = w_dreq & ~w_grant_d;

  always_comb begin
    w_rd_src_nxt = RD_NONE;
    if (w_grant_i)                 w_rd_src_nxt = RD_FETCH;
    else if (w_grant_d && MemRead) w_rd_src_nxt = w_oor ? RD_ERR : RD_DATA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_src     <= RD_NONE;
      r_starve_cnt <= '0;
      r_err        <= 1'b0;
      r_instr      <= NOP;
      r_dread      <= '0;
    end else begin
      r_rd_src <= w_rd_src_nxt;
      r_err    <= w_grant_d & w_oor;
      if (!iMemRead || w_grant_i)
        r_starve_cnt <= '0;
      else if (w_grant_d && r_starve_cnt != LIM)
        r_starve_cnt <= r_starve_cnt + 1'b1;
      if (r_rd_src == RD_FETCH) r_instr <= mem_rdata;
      if (r_rd_src == RD_DATA)  r_dread <= mem_rdata;
      if (r_rd_src == RD_ERR)   r_dread <= '0;
    end
  end

  // RAM data arrives the cycle after the grant; present it directly then hold it.
  assign instruction = (r_rd_src == RD_FETCH) ? mem_rdata : r_instr;
  assign dReadData   = (r_rd_src == RD_DATA) ? mem_rdata :
                       (r_rd_src == RD_ERR)  ? 32'h0     : r_dread;
  assign iValid      = (r_rd_src == RD_FETCH);
  assign dValid      = (r_rd_src == RD_DATA) || (r_rd_src == RD_ERR);
  assign dErr        = r_err;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Randomized bench for riscv_mem_arbiter: RAM environment, behavioural model, directed anchors.
module tb_riscv_mem_arbiter;

  localparam logic [31:0] TB_TEXT = 32'h00000000;
  localparam logic [31:0] TB_DATA = 32'h00002000;
  localparam int          DW      = 2048;
  localparam int          LIM     = 4;

  logic        clk, rst;
  logic        iMemRead, MemRead, MemWrite;
  logic [31:0] PC, dAddress, dWriteData;
  logic [31:0] instruction, dReadData, mem_addr, mem_wdata, mem_rdata;
  logic        iStall, dStall, iValid, dValid, dErr, mem_en, mem_we;

  riscv_mem_arbiter #(.TEXT_BASE(TB_TEXT), .DATA_BASE(TB_DATA), .DATA_WORDS(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .iMemRead(iMemRead), .PC(PC), .MemRead(MemRead), .MemWrite(MemWrite),
    .dAddress(dAddress), .dWriteData(dWriteData), .instruction(instruction), .dReadData(dReadData),
    .iStall(iStall), .dStall(dStall), .iValid(iValid), .dValid(dValid), .dErr(dErr),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: 1-cycle read latency, content pattern C0DE_xxxx until written.
  logic [31:0] ram [0:4095];
  logic        ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 4096; k++) ram[k] <= 32'hC0DE0000 | 32'(k);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[11:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[11:0]];
    end
  end

  int n_vec, n_err;

  // Model state: what the previous cycle granted and the held output values.
  // m_prev: 0 none, 1 fetch, 2 data read, 3 out-of-range read, 4 out-of-range write
  logic [31:0] shadow [0:4095];
  int          m_prev, m_starve;
  logic [31:0] m_val, m_instr, m_dread;
  logic        g_i, g_d, g_oor;
  logic [11:0] g_idx;
  logic        f_pend, d_pend, d_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_starve = 0; m_instr = 32'h13; m_dread = 32'h0;
  endtask

  task automatic check_cycle();
    logic dreq, gi, gd, oor, e_en, e_we;
    logic [31:0] e_addr, e_instr, e_dr;
    longint da;
    @(negedge clk);
    dreq = MemRead | MemWrite;
    da   = longint'(dAddress);
    oor  = (da < longint'(TB_DATA)) || (da >= longint'(TB_DATA) + 4 * DW);
    gi   = !rst && iMemRead && (!dreq || m_starve == LIM);
    gd   = !rst && dreq && !gi;
    e_en = gi || (gd && !oor);
    e_we = gd && MemWrite && !oor;
    e_addr = gi ? (PC - TB_TEXT) >> 2 : ((TB_DATA - TB_TEXT) >> 2) + ((dAddress - TB_DATA) >> 2);
    g_i = gi; g_d = gd; g_oor = oor; g_idx = e_addr[11:0];
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    if (e_en) chk("mem_addr", mem_addr, e_addr);
    if (e_we) chk("mem_wdata", mem_wdata, dWriteData);
    chk("iStall", 32'(iStall), 32'(iMemRead && !gi));
    chk("dStall", 32'(dStall), 32'(dreq && !gd));
    e_instr = (m_prev == 1) ? m_val : m_instr;
    e_dr    = (m_prev == 2) ? m_val : (m_prev == 3) ? 32'h0 : m_dread;
    chk("iValid", 32'(iValid), 32'(m_prev == 1));
    chk("dValid", 32'(dValid), 32'(m_prev == 2 || m_prev == 3));
    chk("dErr", 32'(dErr), 32'(m_prev == 3 || m_prev == 4));
    chk("instruction", instruction, e_instr);
    chk("dReadData", dReadData, e_dr);
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      if (m_prev == 1) m_instr = m_val;
      if (m_prev == 2) m_dread = m_val;
      if (m_prev == 3) m_dread = 32'h0;
      m_prev = 0;
      if (g_i) begin
        m_prev = 1; m_val = shadow[g_idx];
      end else if (g_d) begin
        if (g_oor)        m_prev = MemRead ? 3 : 4;
        else if (MemRead) begin m_prev = 2; m_val = shadow[g_idx]; end
        else              shadow[g_idx] = dWriteData;
      end
      if (!iMemRead || g_i) m_starve = 0;
      else if (g_d && m_starve < LIM) m_starve++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_random();
    int r;
    if (g_i) f_pend = 1'b0;
    if (g_d) d_pend = 1'b0;
    if (f_pend && $urandom_range(0, 19) == 0) f_pend = 1'b0;
    if (!f_pend && $urandom_range(0, 2) != 0) begin
      f_pend = 1'b1;
      PC = 32'($urandom_range(0, 32'h1FFF));
    end
    if (d_pend && $urandom_range(0, 19) == 0) d_pend = 1'b0;
    if (!d_pend && $urandom_range(0, 3) != 0) begin
      d_pend = 1'b1;
      d_wr   = 1'($urandom_range(0, 1));
      dWriteData = $urandom;
      r = int'($urandom_range(0, 9));
      if (r == 0)      dAddress = 32'($urandom_range(0, 32'h1FFF));
      else if (r == 1) dAddress = 32'h4000 + 32'($urandom_range(0, 32'hFFFF));
      else             dAddress = TB_DATA + 32'($urandom_range(0, 32'h1FFF));
    end
    iMemRead = f_pend;
    MemRead  = d_pend & ~d_wr;
    MemWrite = d_pend & d_wr;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; ram_init = 1'b1;
    iMemRead = 0; MemRead = 0; MemWrite = 0; PC = 0; dAddress = 0; dWriteData = 0;
    f_pend = 0; d_pend = 0; d_wr = 0; g_i = 0; g_d = 0; g_oor = 0; g_idx = 0; m_val = 0;
    for (int k = 0; k < 4096; k++) shadow[k] = 32'hC0DE0000 | 32'(k);
    model_reset();

    check_cycle();
    chk("rst_instr", instruction, 32'h00000013);
    chk("rst_dread", dReadData, 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    tick();
    ram_init = 1'b0;
    check_cycle(); tick();
    rst = 1'b0;

    // fetch only
    iMemRead = 1; PC = 32'h8;
    check_cycle(); chk("fo_addr", mem_addr, 32'd2); chk("fo_istall", 32'(iStall), 32'h0); tick();
    iMemRead = 0;
    check_cycle(); chk("fo_instr", instruction, 32'hC0DE0002); chk("fo_ivalid", 32'(iValid), 32'h1); tick();

    // simultaneous fetch and load: data first
    iMemRead = 1; PC = 32'h0; MemRead = 1; dAddress = 32'h2004;
    check_cycle(); chk("sim_addr", mem_addr, 32'h801); chk("sim_istall", 32'(iStall), 32'h1); tick();
    MemRead = 0;
    check_cycle(); chk("sim_faddr", mem_addr, 32'h0); chk("sim_dread", dReadData, 32'hC0DE0801); tick();
    iMemRead = 0;
    check_cycle(); chk("sim_instr", instruction, 32'hC0DE0000); tick();

    // starvation: 4 data grants, one fetch, then data again
    iMemRead = 1; PC = 32'h10; MemRead = 1; dAddress = 32'h2000;
    for (int k = 0; k < 6; k++) begin
      logic [31:0] e;
      e = (k == 4) ? 32'd4 : 32'h800;
      check_cycle(); chk("starve_addr", mem_addr, e); tick();
    end
    iMemRead = 0; MemRead = 0;
    check_cycle(); tick();

    // store then load
    MemWrite = 1; dAddress = 32'h2010; dWriteData = 32'hDEADBEEF;
    check_cycle(); chk("st_we", 32'(mem_we), 32'h1); chk("st_addr", mem_addr, 32'h804); tick();
    MemWrite = 0; MemRead = 1;
    check_cycle(); chk("st_nodvalid", 32'(dValid), 32'h0); tick();
    MemRead = 0;
    check_cycle(); chk("ld_dvalid", 32'(dValid), 32'h1); chk("ld_data", dReadData, 32'hDEADBEEF); tick();

    // out-of-range load
    MemRead = 1; dAddress = 32'h1000;
    check_cycle(); chk("oor_en", 32'(mem_en), 32'h0); tick();
    MemRead = 0;
    check_cycle(); chk("oor_derr", 32'(dErr), 32'h1); chk("oor_dvalid", 32'(dValid), 32'h1);
    chk("oor_data", dReadData, 32'h0); tick();

    g_i = 0; g_d = 0;
    repeat (3000) begin
      drive_random();
      check_cycle();
      tick();
    end

    // asynchronous reset in the cycle after a fetch grant
    iMemRead = 0; MemRead = 0; MemWrite = 0;
    check_cycle(); tick();
    iMemRead = 1; PC = 32'h20;
    check_cycle(); tick();
    rst = 1'b1; model_reset(); iMemRead = 0;
    #1;
    chk("arst_ivalid", 32'(iValid), 32'h0);
    chk("arst_instr", instruction, 32'h00000013);
    chk("arst_mem_en", 32'(mem_en), 32'h0);
    check_cycle(); tick();
    rst = 1'b0;
    check_cycle(); chk("arst_after_ivalid", 32'(iValid), 32'h0); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 Parameters SHALL be `TEXT_BASE` (default 32'h00000000, the instruction segment base) and `DATA_BASE` (default 32'h00002000, the data segment base).
REQ-002 Parameters SHALL also include `DATA_WORDS` (default 2048, data segment size in words) and `STARVE_LIMIT` (default 4, the maximum consecutive data grants while a fetch waits).
REQ-003 Port `clk` SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port `rst` SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-005 Port `iMemRead` SHALL be an input, 1 bit: fetch request, held until granted.
REQ-006 Port `PC` SHALL be an input, 32 bits: fetch byte address.
REQ-007 Ports `MemRead` and `MemWrite` SHALL be inputs, 1 bit each: data read or write request, held until granted; never both high.
REQ-008 Port `dAddress` SHALL be an input, 32 bits: data byte address.
REQ-009 Port `dWriteData` SHALL be an input, 32 bits: store data.
REQ-010 Port `instruction` SHALL be an output, 32 bits: fetched word, registered.
REQ-011 Port `dReadData` SHALL be an output, 32 bits: loaded word, registered.
REQ-012 Ports `iStall` and `dStall` SHALL be outputs, 1 bit each, combinational: request present and not granted this cycle.
REQ-013 Ports `iValid` and `dValid` SHALL be outputs, 1 bit each: one-cycle pulse when `instruction` / `dReadData` is updated.
REQ-014 Port `dErr` SHALL be an output, 1 bit: pulse, the granted data access was outside the data segment.
REQ-015 Ports `mem_en` and `mem_we` SHALL be outputs, 1 bit each, driving a single-port synchronous RAM with a 1-cycle read latency.
REQ-016 Port `mem_addr` SHALL be an output, 32 bits: word index into the unified RAM.
REQ-017 Port `mem_wdata` SHALL be an output, 32 bits; port `mem_rdata` SHALL be an input, 32 bits.

Function
REQ-018 At most one request SHALL be granted per cycle; a grant drives `mem_en`=1 that cycle.
REQ-019 Priority SHALL go to a data request over a fetch request, except as given in REQ-020.
REQ-020 A fetch SHALL be granted instead of a pending data request when `starve_cnt` == `STARVE_LIMIT`.
REQ-021 `starve_cnt` SHALL increment on each data grant while `iMemRead` is high, saturating at `STARVE_LIMIT`.
REQ-022 `starve_cnt` SHALL clear on any fetch grant or whenever `iMemRead` is low.
REQ-023 A fetch grant SHALL drive `mem_addr` = (`PC` - `TEXT_BASE`) >> 2 and `mem_we` = 0.
REQ-024 A data grant SHALL drive `mem_addr` = `DATA_WORD_OFFSET` + ((`dAddress` - `DATA_BASE`) >> 2), where `DATA_WORD_OFFSET` = (`DATA_BASE` - `TEXT_BASE`) >> 2.
REQ-025 A data write grant SHALL drive `mem_we` = 1 and `mem_wdata` = `dWriteData`.
REQ-026 A data access with `dAddress` < `DATA_BASE` or `dAddress` >= `DATA_BASE` + 4*`DATA_WORDS` SHALL be granted with `mem_en` = 0.
REQ-027 That out-of-range access SHALL pulse `dErr` the following cycle.
REQ-028 An out-of-range read SHALL load `dReadData` = 0 with `dValid` = 1 the following cycle; an out-of-range write SHALL be dropped.
REQ-029 A registered tag `rd_src` SHALL record whether the previous cycle granted a fetch read, a data read, or nothing.
REQ-030 On the cycle after a fetch grant, `instruction` SHALL load `mem_rdata` and `iValid` SHALL be 1.
REQ-031 On the cycle after a data read grant, `dReadData` SHALL load `mem_rdata` and `dValid` SHALL be 1.
REQ-032 A write SHALL NOT produce `dValid`.
REQ-033 Read latency SHALL be exactly 1 cycle from grant to valid.
REQ-034 `instruction` and `dReadData` SHALL hold their values between valid pulses.
REQ-035 When neither requester is active, `mem_en` SHALL be 0 and all state SHALL be held except REQ-022.
REQ-036 A request dropped before it is granted SHALL be ignored, with no side effect.

Reset
REQ-037 While `rst` is high, `instruction` SHALL be 32'h00000013 (NOP) and `dReadData` SHALL be 0.
REQ-038 While `rst` is high, `iValid`, `dValid`, `dErr`, `mem_en` and `mem_we` SHALL be 0, `starve_cnt` SHALL be 0, and `rd_src` SHALL be none.
REQ-039 A reset asserted in the cycle after a grant SHALL discard the pending read data, and no valid pulse SHALL follow.
REQ-040 After `rst` deasserts, the first request SHALL be serviced on the next clock edge.

Verification
REQ-041 Fetch only: `PC`=0x8 held with `iMemRead`=1 -> `mem_addr`=2, then `instruction`=RAM[2] with `iValid`=1 one cycle later; `iStall` stays 0.
REQ-042 Simultaneous fetch and load: `PC`=0x0 and `dAddress`=0x2004 -> the data grant goes first (`mem_addr`=0x801) with `iStall`=1; the fetch is granted the next cycle.
REQ-043 Starvation: a fetch pending with `STARVE_LIMIT`=4 while data requests are held continuously -> 4 data grants, then 1 fetch grant, then data resumes.
REQ-044 Store then load to 0x2010 with value 0xDEADBEEF -> the write cycle has `mem_we`=1 and no `dValid`; the load returns 0xDEADBEEF.
REQ-045 Load from 0x1000 -> `mem_en`=0, then `dErr`=1, `dValid`=1 and `dReadData`=0.
REQ-046 Reset asserted asynchronously mid-grant -> outputs follow REQ-037 and REQ-038 immediately and no `iValid` or `dValid` follows.
